pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the vector CPU. It generates the load enables for the fetch, decode, execute and writeback stage registers, detects read-after-write and write-after-write hazards with a per-register scoreboard, and inserts NOP bubbles (opcode 5'b11110) into the execute and writeback stage registers. It also holds the execute stage for multi-cycle vector operations. It sits beside the decode stage and drives the `en` pins of every stage register.

## Interface

Parameters:
- `VEC_LAT`, default 4: execute-stage occupancy in cycles of a multi-cycle vector op; legal range 1..15.
- `NOP_OP`, default 5'b11110: bubble opcode, used only to document the mux select meaning.

Ports:
- `clk`, in, 1: clock; all state updates on the falling edge, aligned with the stage registers.
- `reset`, in, 1: synchronous, active-high.
- `dec_valid`, in, 1: decode stage holds a real instruction.
- `dec_src1`, in, 3: first source register index.
- `dec_src2`, in, 3: second source register index.
- `dec_use1`, in, 1: the instruction reads `dec_src1`.
- `dec_use2`, in, 1: the instruction reads `dec_src2`.
- `dec_src_vec`, in, 1: sources are in the vector file (1) or the scalar file (0).
- `dec_writes`, in, 1: the instruction writes `dec_dst`.
- `dec_dst`, in, 3: destination register index.
- `dec_dst_vec`, in, 1: destination is in the vector file.
- `dec_multi`, in, 1: the instruction is a multi-cycle vector op.
- `wb_valid`, in, 1: the writeback stage commits this cycle.
- `wb_dst`, in, 3: destination register being committed.
- `wb_vec`, in, 1: the committed destination is in the vector file.
- `en_fetch`, out, 1: enable for the fetch stage register.
- `en_decode`, out, 1: enable for the decode stage register.
- `en_execute`, out, 1: enable for the execute stage register.
- `en_wb`, out, 1: enable for the writeback stage register.
- `ex_nop`, out, 1: execute register loads `NOP_OP` in place of the decoded opcode.
- `wb_nop`, out, 1: writeback register loads a bubble.
- `issue`, out, 1: the decode instruction enters execute this cycle.
- `busy`, out, 1: FSM is in MULTI.

## Operation

Scoreboard:
- Two 8-bit pending vectors, `sb_s` (scalar) and `sb_v` (vector); both cleared by reset.
- Hazard (combinational, from registered scoreboard state):
  - RAW: `dec_use1` and the bit for `dec_src1` is set in the file selected by `dec_src_vec`; likewise for `dec_src2` with `dec_use2`.
  - WAW: `dec_writes` and the bit for `dec_dst` is set in the file selected by `dec_dst_vec`.
- `stall` = `dec_valid` & hazard.
- `issue` = `dec_valid` & ~hazard & state==IDLE.
- On `issue` with `dec_writes`, set the pending bit for `dec_dst`.
- On `wb_valid`, clear the pending bit for `wb_dst`.
- Same bit set and cleared in the same cycle: set wins.
- No bypass. A source cleared this cycle still stalls this cycle; the stall releases next cycle.

FSM, states IDLE and MULTI, with a 4-bit down-counter `cnt`:
- IDLE, `issue` & `dec_multi` & `VEC_LAT`>1: go to MULTI, `cnt`=`VEC_LAT`-1.
- MULTI: `cnt` decrements each cycle. When `cnt`==1, return to IDLE on the next edge.
- With `VEC_LAT`==1, MULTI is never entered.

Outputs:
- IDLE, no stall: all four enables 1; `ex_nop`=0; `wb_nop`=0.
- IDLE, stall: `en_fetch`=0, `en_decode`=0, `en_execute`=1 with `ex_nop`=1 (bubble), `en_wb`=1.
- IDLE, `dec_valid`=0: enables 1; `ex_nop`=1.
- MULTI: `en_fetch`, `en_decode` and `en_execute` are 0 (execute holds its instruction); `en_wb`=1 with `wb_nop`=1; `issue`=0; `busy`=1.
- Reset asserted: all enables 0, `ex_nop`=1, `wb_nop`=1, `issue`=0, `busy`=0. The following cycle, state is IDLE with an empty scoreboard.
- Reset mid-MULTI or with bits pending: everything is discarded; no writeback clears are expected afterwards.

## Timing

- Enables, `ex_nop`, `wb_nop` and `issue` are combinational from state and the current inputs, valid before the falling edge.
- Scoreboard and FSM are registered on the falling edge.
- Dependent instruction directly behind a single-cycle producer: it stalls until the producer's `wb_valid` edge, then issues on the next cycle.
- Multi-cycle op: execute occupancy is exactly `VEC_LAT` cycles (1 issue cycle plus `VEC_LAT`-1 MULTI cycles).
- Writeback of the multi-cycle op follows the last MULTI cycle.
- `wb_valid` is honoured in every state, including MULTI.

## Structure

- Shared package `geva_pipe_pkg` holds:
  - the state enum (IDLE, MULTI);
  - the constant `NOP_OP`=5'b11110;
  - the constant `REG_IDX_W`=3.
- One sub-module, `reg_scoreboard`: the two pending vectors, their set/clear logic and the hazard compare. It is instantiated once.
- The FSM and output decode live in the top module.

## Test plan

- Reset held 2 cycles, then released with `dec_valid`=0 -> during reset all enables 0, `ex_nop`=1; after release enables 1, `busy`=0, `sb_s`=`sb_v`=0.
- Issue writing scalar r3, then a consumer reading r3 -> `stall` with `en_fetch`=0 and `ex_nop`=1 until the `wb_valid`/`wb_dst`=3 edge; `issue`=1 on the following cycle.
- Vector v2 pending, decode reads scalar r2 -> no stall; `issue`=1 (files independent).
- `dec_multi`=1 with `VEC_LAT`=4 -> `busy`=1 for exactly 3 cycles; `en_execute`=0 and `wb_nop`=1 in each; IDLE on the 4th cycle.
- Same cycle: `wb_valid` clears r5 while `issue` sets r5 -> r5 remains pending; a later WAW on r5 stalls.
- Reset asserted during MULTI with `cnt`=2 and r1 pending -> next cycle IDLE, `busy`=0, no hazard on r1.

Source files
------------

// File: rtl/geva_pipe_pkg.sv
// rtl/geva_pipe_pkg.sv - shared types and constants for the pipeline sequencing controller
package geva_pipe_pkg;

  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned NUM_REGS  = 1 << REG_IDX_W;

  localparam logic [4:0] NOP_OP = 5'b11110;

  typedef enum logic {
    IDLE  = 1'b0,
    MULTI = 1'b1
  } pipe_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending bits for the scalar and vector files plus RAW/WAW compare
module reg_scoreboard
  import geva_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 set_vec,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic                 clr_vec,
  input  logic                 use1,
  input  logic [REG_IDX_W-1:0] src1,
  input  logic                 use2,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 src_vec,
  input  logic                 writes,
  input  logic [REG_IDX_W-1:0] dst,
  input  logic                 dst_vec,
  output logic                 hazard
);

  logic [NUM_REGS-1:0] sb_s;
  logic [NUM_REGS-1:0] sb_v;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] src_file;
  logic [NUM_REGS-1:0] dst_file;

  always_comb begin
    set_mask          = '0;
    clr_mask          = '0;
    set_mask[set_idx] = set_en;
    clr_mask[clr_idx] = clr_en;
  end

  // Clear first, then OR in the set so a same-cycle set/clear leaves the bit pending.
  always_ff @(negedge clk) begin
    if (reset) begin
      sb_s <= '0;
      sb_v <= '0;
    end else begin
      sb_s <= (sb_s & ~(clr_vec ? '0 : clr_mask)) | (set_vec ? '0 : set_mask);
      sb_v <= (sb_v & ~(clr_vec ? clr_mask : '0)) | (set_vec ? set_mask : '0);
    end
  end

  always_comb begin
    src_file = src_vec ? sb_v : sb_s;
    dst_file = dst_vec ? sb_v : sb_s;
    hazard   = (use1 & src_file[src1]) | (use2 & src_file[src2]) | (writes & dst_file[dst]);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stage enables, bubble insertion and multi-cycle execute hold
module pipe_hazard_ctrl
  import geva_pipe_pkg::*;
#(
  parameter int unsigned VEC_LAT = 4,
  parameter logic [4:0]  NOP_OP  = geva_pipe_pkg::NOP_OP
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [REG_IDX_W-1:0] dec_src1,
  input  logic [REG_IDX_W-1:0] dec_src2,
  input  logic                 dec_use1,
  input  logic                 dec_use2,
  input  logic                 dec_src_vec,
  input  logic                 dec_writes,
  input  logic [REG_IDX_W-1:0] dec_dst,
  input  logic                 dec_dst_vec,
  input  logic                 dec_multi,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_dst,
  input  logic                 wb_vec,
  output logic                 en_fetch,
  output logic                 en_decode,
  output logic                 en_execute,
  output logic                 en_wb,
  output logic                 ex_nop,
  output logic                 wb_nop,
  output logic                 issue,
  output logic                 busy
);

  generate
    if (VEC_LAT < 1 || VEC_LAT > 15 || NOP_OP == 5'd0) begin : g_bad_param
      $error("pipe_hazard_ctrl: VEC_LAT must be 1..15 and NOP_OP nonzero");
    end
  endgenerate

  pipe_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        hazard;

  reg_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (issue & dec_writes),
    .set_idx (dec_dst),
    .set_vec (dec_dst_vec),
    .clr_en  (wb_valid),
    .clr_idx (wb_dst),
    .clr_vec (wb_vec),
    .use1    (dec_use1),
    .src1    (dec_src1),
    .use2    (dec_use2),
    .src2    (dec_src2),
    .src_vec (dec_src_vec),
    .writes  (dec_writes),
    .dst     (dec_dst),
    .dst_vec (dec_dst_vec),
    .hazard  (hazard)
  );

  always_ff @(negedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Defaults are the reset-time outputs: every stage frozen, both bubbles selected.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    en_fetch   = 1'b0;
    en_decode  = 1'b0;
    en_execute = 1'b0;
    en_wb      = 1'b0;
    ex_nop     = 1'b1;
    wb_nop     = 1'b1;
    issue      = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          en_execute = 1'b1;
          en_wb      = 1'b1;
          wb_nop     = 1'b0;
          if (!dec_valid) begin
            en_fetch  = 1'b1;
            en_decode = 1'b1;
          end else if (!hazard) begin
            en_fetch  = 1'b1;
            en_decode = 1'b1;
            ex_nop    = 1'b0;
            issue     = 1'b1;
            if (dec_multi && VEC_LAT > 1) begin
              state_nxt = MULTI;
              cnt_nxt   = 4'(VEC_LAT - 1);
            end
          end
        end
        MULTI: begin
          en_wb   = 1'b1;
          ex_nop  = 1'b0;
          busy    = 1'b1;
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized bench against a register-level behavioural model
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b1;
  logic       reset;
  logic       dec_valid, dec_use1, dec_use2, dec_src_vec, dec_writes, dec_dst_vec, dec_multi;
  logic [2:0] dec_src1, dec_src2, dec_dst;
  logic       wb_valid, wb_vec;
  logic [2:0] wb_dst;
  logic       en_fetch, en_decode, en_execute, en_wb, ex_nop, wb_nop, issue, busy;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.VEC_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_src1(dec_src1), .dec_src2(dec_src2),
    .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_src_vec(dec_src_vec),
    .dec_writes(dec_writes), .dec_dst(dec_dst), .dec_dst_vec(dec_dst_vec),
    .dec_multi(dec_multi), .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_vec(wb_vec),
    .en_fetch(en_fetch), .en_decode(en_decode), .en_execute(en_execute), .en_wb(en_wb),
    .ex_nop(ex_nop), .wb_nop(wb_nop), .issue(issue), .busy(busy)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Model: which registers await writeback, and how many hold cycles remain.
  bit         pend_s [8];
  bit         pend_v [8];
  int         hold_left = 0;
  bit         exp_issue;
  logic [7:0] exp_out, mask;

  function automatic bit pending(input bit vec, input logic [2:0] idx);
    return vec ? pend_v[idx] : pend_s[idx];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      exp_issue = 1'b0;
      mask      = 8'hff;
      if (reset) begin
        exp_out = 8'b0000_1100;
      end else if (hold_left > 0) begin
        exp_out = 8'b0001_0101;
        mask    = 8'b1111_0111;
      end else if (!dec_valid) begin
        exp_out = 8'b1111_1000;
      end else if ((dec_use1 && pending(dec_src_vec, dec_src1)) ||
                   (dec_use2 && pending(dec_src_vec, dec_src2)) ||
                   (dec_writes && pending(dec_dst_vec, dec_dst))) begin
        exp_out = 8'b0011_1000;
      end else begin
        exp_out   = 8'b1111_0010;
        exp_issue = 1'b1;
      end
      chk("outputs{enF,enD,enE,enW,exNop,wbNop,issue,busy}",
          {en_fetch, en_decode, en_execute, en_wb, ex_nop, wb_nop, issue, busy} & mask,
          exp_out & mask);
      @(negedge clk);
      if (reset) begin
        for (int i = 0; i < 8; i++) begin
          pend_s[i] = 1'b0;
          pend_v[i] = 1'b0;
        end
        hold_left = 0;
      end else begin
        if (wb_valid) begin
          if (wb_vec) pend_v[wb_dst] = 1'b0;
          else        pend_s[wb_dst] = 1'b0;
        end
        if (exp_issue && dec_writes) begin
          if (dec_dst_vec) pend_v[dec_dst] = 1'b1;
          else             pend_s[dec_dst] = 1'b1;
        end
        if (hold_left > 0) hold_left--;
        else if (exp_issue && dec_multi) hold_left = LAT - 1;
      end
    end
  end

  task automatic dec(input logic v, input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                     input logic u2, input logic sv, input logic w, input logic [2:0] d,
                     input logic dv, input logic m);
    dec_valid = v; dec_src1 = s1; dec_use1 = u1; dec_src2 = s2; dec_use2 = u2;
    dec_src_vec = sv; dec_writes = w; dec_dst = d; dec_dst_vec = dv; dec_multi = m;
  endtask

  task automatic wb(input logic v, input logic [2:0] d, input logic vec);
    wb_valid = v; wb_dst = d; wb_vec = vec;
  endtask

  initial begin
    reset = 1'b1;
    dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    @(posedge clk); #3;
    chk("rst_en_fetch", en_fetch, 0);
    chk("rst_ex_nop", ex_nop, 1);
    @(posedge clk); #3;
    chk("rst_en_wb", en_wb, 0);
    @(posedge clk); reset = 1'b0; #3;
    chk("idle_enables", {en_fetch, en_decode, en_execute, en_wb}, 4'hf);
    chk("idle_busy", busy, 0);
    chk("idle_ex_nop", ex_nop, 1);

    // Scalar r3 producer, then a dependent reader.
    @(posedge clk); dec(1, 0, 0, 0, 0, 0, 1, 3, 0, 0); #3;
    chk("r3_producer_issue", issue, 1);
    @(posedge clk); dec(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); #3;
    chk("r3_raw_issue", issue, 0);
    chk("r3_raw_en_fetch", en_fetch, 0);
    chk("r3_raw_ex_nop", ex_nop, 1);
    @(posedge clk); wb(1, 3, 0); #3;
    chk("r3_clear_cycle_still_stalls", issue, 0);
    @(posedge clk); wb(0, 0, 0); #3;
    chk("r3_released_issue", issue, 1);

    // Vector v2 pending does not block scalar r2.
    @(posedge clk); dec(1, 0, 0, 0, 0, 0, 1, 2, 1, 0); #3;
    chk("v2_producer_issue", issue, 1);
    @(posedge clk); dec(1, 2, 1, 2, 1, 0, 0, 0, 0, 0); #3;
    chk("scalar_r2_vs_v2_issue", issue, 1);

    // Multi-cycle op; v2 cleared by a writeback while held.
    @(posedge clk); dec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); #3;
    chk("multi_issue", issue, 1);
    chk("multi_issue_busy", busy, 0);
    for (int i = 0; i < LAT - 1; i++) begin
      @(posedge clk); dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); wb(i == 1, 2, 1); #3;
      chk("multi_hold", {busy, en_execute, wb_nop}, 3'b101);
    end
    @(posedge clk); wb(0, 0, 0); dec(1, 2, 1, 0, 0, 1, 0, 0, 0, 0); #3;
    chk("multi_done_busy", busy, 0);
    chk("v2_cleared_in_multi_issue", issue, 1);

    // Same-cycle set and clear of r5: set wins.
    @(posedge clk); dec(1, 0, 0, 0, 0, 0, 1, 5, 0, 0); wb(1, 5, 0); #3;
    chk("r5_set_issue", issue, 1);
    @(posedge clk); wb(0, 0, 0); dec(1, 0, 0, 0, 0, 0, 1, 5, 0, 0); #3;
    chk("r5_waw_issue", issue, 0);
    chk("r5_waw_en_fetch", en_fetch, 0);

    // Reset in the middle of a hold with r1 pending.
    @(posedge clk); wb(1, 5, 0); dec(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); #3;
    chk("r1_producer_issue", issue, 1);
    @(posedge clk); wb(0, 0, 0); dec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); #3;
    chk("multi2_issue", issue, 1);
    @(posedge clk); dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #3;
    chk("multi2_busy_first", busy, 1);
    @(posedge clk); reset = 1'b1; #3;
    chk("reset_in_multi_outputs", {busy, en_wb, wb_nop, issue}, 4'b0010);
    @(posedge clk); reset = 1'b0; dec(1, 1, 1, 0, 0, 0, 1, 1, 0, 0); #3;
    chk("after_reset_busy", busy, 0);
    chk("after_reset_r1_issue", issue, 1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      reset = ($urandom_range(0, 149) == 0);
      dec($urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), $urandom_range(0, 4) == 0);
      wb($urandom_range(0, 2) != 0, 3'($urandom), 1'($urandom));
    end

    @(posedge clk); reset = 1'b0;
    #5;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
